instr_fetch_unit: RTL

//  Responder side of the core's fetch interface: owns the PC, services flash_read/pc_inc/pc_load from

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/fetch_prefetch_buf.sv | 32 +++
 rtl/instr_fetch_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and defaults for the instruction fetch unit
package instr_fetch_unit_pkg;

    localparam int IFU_ADDR_W  = 16;
    localparam int IFU_INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_READY = 2'd2,
        ST_ERR   = 2'd3
    } ifu_state_e;

    // Wide enough to hold every count value up to and including the timeout limit.
    function automatic int ifu_cnt_w(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/fetch_prefetch_buf.sv
// rtl/fetch_prefetch_buf.sv - one-entry prefetch buffer (valid, addr, data, flush)
module fetch_prefetch_buf #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fill,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  fill_addr,
    input  logic [INSTR_W-1:0] fill_data,
    output logic               valid,
    output logic [ADDR_W-1:0]  addr,
    output logic [INSTR_W-1:0] data
);

    // Flush wins so a branch can never leave stale sequential data behind.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            addr  <= fill_addr;
            data  <= fill_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and flash fetch FSM; IFU_PREFETCH_EN adds a one-entry prefetch buffer
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W       = IFU_ADDR_W,
    parameter int                INSTR_W      = IFU_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                TIMEOUT_CYC  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flash_read,
    input  logic               pc_inc,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               fl_req,
    output logic [ADDR_W-1:0]  fl_addr,
    input  logic               fl_ack,
    input  logic [INSTR_W-1:0] fl_rdata,
    output logic               fetch_err
);

    localparam int               CNT_W    = ifu_cnt_w(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    ifu_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               ack;
    logic               advance;
    logic               timeout_hit;
    logic [ADDR_W-1:0]  pc_seq;
    logic [ADDR_W-1:0]  adv_pc;

    assign ack         = fl_ack & req_q;
    assign advance     = (state_q == ST_READY) & flash_read & (pc_load | pc_inc);
    assign timeout_hit = req_q & ~fl_ack & (cnt_q >= CNT_LAST);
    assign pc_seq      = pc_q + 1'b1;
    assign adv_pc      = pc_load ? branch_target : pc_seq;

`ifdef IFU_PREFETCH_EN
    logic               discard_q, discard_d;
    logic               buf_fill, buf_flush, buf_valid, buf_hit;
    logic [ADDR_W-1:0]  buf_addr;
    logic [INSTR_W-1:0] buf_data;

    fetch_prefetch_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_pf_buf (
        .clk       (clk),
        .reset     (reset),
        .fill      (buf_fill),
        .flush     (buf_flush),
        .fill_addr (addr_q),
        .fill_data (fl_rdata),
        .valid     (buf_valid),
        .addr      (buf_addr),
        .data      (buf_data)
    );

    assign buf_hit = buf_valid & (buf_addr == pc_seq);

    always_ff @(posedge clk) begin
        if (!reset) discard_q <= 1'b0;
        else        discard_q <= discard_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            instr_q <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
`ifdef IFU_PREFETCH_EN
        discard_d = discard_q;
        buf_fill  = 1'b0;
        buf_flush = 1'b0;
`endif
        if (req_q && !fl_ack) cnt_d = cnt_q + 1'b1;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
                cnt_d   = '0;
            end
            ST_FETCH: begin
`ifdef IFU_PREFETCH_EN
                // A dropped request (after a discarded prefetch) is reissued one idle cycle later.
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                    cnt_d  = '0;
                end else if (ack) begin
                    req_d = 1'b0;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        instr_d = fl_rdata;
                        state_d = ST_READY;
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    state_d = ST_ERR;
                end
`else
                if (ack) begin
                    req_d   = 1'b0;
                    instr_d = fl_rdata;
                    state_d = ST_READY;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    state_d = ST_ERR;
                end
`endif
            end
            ST_READY: begin
`ifdef IFU_PREFETCH_EN
                if (advance && pc_load) begin
                    pc_d      = branch_target;
                    buf_flush = 1'b1;
                    state_d   = ST_FETCH;
                    if (req_q && !fl_ack) begin
                        discard_d = 1'b1;
                    end else if (req_q) begin
                        req_d = 1'b0;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = branch_target;
                        cnt_d  = '0;
                    end
                end else if (advance) begin
                    pc_d = pc_seq;
                    if (buf_hit) begin
                        instr_d   = buf_data;
                        buf_flush = 1'b1;
                    end else if (ack) begin
                        instr_d = fl_rdata;
                        req_d   = 1'b0;
                    end else if (req_q) begin
                        state_d = ST_FETCH;
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = pc_seq;
                        cnt_d   = '0;
                        state_d = ST_FETCH;
                    end
                end else if (ack) begin
                    buf_fill = 1'b1;
                    req_d    = 1'b0;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    state_d = ST_ERR;
                end else if (!req_q && !buf_valid) begin
                    req_d  = 1'b1;
                    addr_d = pc_seq;
                    cnt_d  = '0;
                end
`else
                if (advance) begin
                    pc_d    = adv_pc;
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    addr_d  = adv_pc;
                    cnt_d   = '0;
                end
`endif
            end
            ST_ERR: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = ST_ERR;
                req_d   = 1'b0;
            end
        endcase
    end

    assign instr_out   = instr_q;
    assign instr_valid = (state_q == ST_READY);
    assign pc_out      = pc_q;
    assign fl_req      = req_q;
    assign fl_addr     = addr_q;
    assign fetch_err   = (state_q == ST_ERR);

endmodule
